// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU operation per request and returns its result
// Drives ALU operands, one-hot op select, T beats and EALU; multi-beat MUL/DIV sequences included.
module alu_op_sequencer #(
    parameter int SIMPLE_BEATS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_c,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_t,
    output logic [10:0] alu_sel,
    output logic        alu_en,
    input  logic [7:0]  alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_lo,
    output logic [7:0]  res_hi,
    output logic        res_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_LAST = 4'd10;

    localparam int LAST = SIMPLE_BEATS - 1;

    logic [1:0]  state;
    logic        is_long;
    logic        is_div;
    logic [7:0]  divisor;
    logic        op_bad;
    logic        accept;
    logic [10:0] op_onehot;

    // A DIV whose high dividend byte reaches the divisor cannot fit an 8-bit quotient.
    always_comb begin
        op_bad = 1'b0;
        if (req_op > OP_LAST) begin
            op_bad = 1'b1;
        end else if (req_op == OP_DIV && (req_c == 8'h00 || req_b >= req_c)) begin
            op_bad = 1'b1;
        end
    end

    assign accept    = req_valid && req_ready;
    assign op_onehot = 11'(1) << req_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_t     <= 8'h00;
            alu_sel   <= 11'h000;
            alu_en    <= 1'b0;
            res_valid <= 1'b0;
            res_lo    <= 8'h00;
            res_hi    <= 8'h00;
            res_err   <= 1'b0;
            is_long   <= 1'b0;
            is_div    <= 1'b0;
            divisor   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (op_bad) begin
                            state <= RESP;
                        end else begin
                            state   <= EXEC;
                            alu_t   <= 8'h01;
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_sel <= op_onehot;
                            alu_en  <= 1'b0;
                            is_long <= (req_op == OP_MUL) || (req_op == OP_DIV);
                            is_div  <= (req_op == OP_DIV);
                            divisor <= req_c;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                EXEC: begin
                    alu_t <= alu_t << 1;
                    if (is_long) begin
                        // EALU covers T6 and T7; divisor replaces the high dividend byte from T5.
                        alu_en <= alu_t[5] | alu_t[6];
                        if (is_div && alu_t[4]) begin
                            alu_b <= divisor;
                        end
                        if (alu_t[6]) begin
                            res_lo <= alu_out;
                        end
                        if (alu_t[7]) begin
                            res_hi    <= alu_out;
                            state     <= RESP;
                            alu_t     <= 8'h00;
                            alu_sel   <= 11'h000;
                            alu_en    <= 1'b0;
                            res_valid <= 1'b1;
                            res_err   <= 1'b0;
                        end
                    end else begin
                        alu_en <= alu_t[LAST-1];
                        if (alu_t[LAST]) begin
                            res_lo    <= alu_out;
                            res_hi    <= 8'h00;
                            state     <= RESP;
                            alu_t     <= 8'h00;
                            alu_sel   <= 11'h000;
                            alu_en    <= 1'b0;
                            res_valid <= 1'b1;
                            res_err   <= 1'b0;
                        end
                    end
                end

                RESP: begin
                    // Entering RESP without res_valid only happens on the error path.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_lo    <= 8'hFF;
                        res_hi    <= 8'hFF;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    alu_t     <= 8'h00;
                    alu_sel   <= 11'h000;
                    alu_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [7:0]  req_a = 8'h00;
    logic [7:0]  req_b = 8'h00;
    logic [7:0]  req_c = 8'h00;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_t;
    logic [10:0] alu_sel;
    logic        alu_en;
    logic [7:0]  alu_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        res_err;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SIMPLE_BEATS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_t(alu_t), .alu_sel(alu_sel), .alu_en(alu_en),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi), .res_err(res_err)
    );

    // Behavioural ALU: dividend latched at T3, divide at T5, quotient out in T6, remainder in T7.
    logic [15:0] dvd;
    logic [7:0]  quo, rem;
    logic [15:0] prod;
    always @(posedge clk) begin
        if (alu_sel[4] && alu_t[3]) dvd <= {alu_b, alu_a};
        if (alu_sel[4] && alu_t[5]) begin
            quo <= (alu_b == 8'h00) ? 8'hEE : 8'(dvd / {8'h00, alu_b});
            rem <= (alu_b == 8'h00) ? 8'hEE : 8'(dvd % {8'h00, alu_b});
        end
    end
    always_comb begin
        alu_out = 8'h00;
        prod    = {8'h00, alu_a} * {8'h00, alu_b};
        case (1'b1)
            alu_sel[0]:  alu_out = alu_a;
            alu_sel[1]:  alu_out = alu_a + alu_b;
            alu_sel[2]:  alu_out = alu_a - alu_b;
            alu_sel[3]:  alu_out = alu_t[7] ? prod[15:8] : prod[7:0];
            alu_sel[4]:  alu_out = alu_t[7] ? rem : quo;
            alu_sel[5]:  alu_out = alu_a | alu_b;
            alu_sel[6]:  alu_out = ~alu_a;
            alu_sel[7]:  alu_out = alu_a & alu_b;
            alu_sel[8]:  alu_out = alu_a ^ alu_b;
            alu_sel[9]:  alu_out = alu_a << 1;
            alu_sel[10]: alu_out = alu_a >> 1;
            default:     alu_out = 8'h00;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {err, hi, lo} for a request.
    function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a, b, c);
        logic [7:0]  r;
        logic [15:0] p, d;
        r = 8'h00;
        case (op)
            4'd0:  r = a;
            4'd1:  r = a + b;
            4'd2:  r = a - b;
            4'd3: begin
                p = {8'h00, a} * {8'h00, b};
                return {1'b0, p};
            end
            4'd4: begin
                if (c == 8'h00 || b >= c) return {1'b1, 16'hFFFF};
                d = {b, a};
                p = d / {8'h00, c};
                d = d % {8'h00, c};
                return {1'b0, d[7:0], p[7:0]};
            end
            4'd5:  r = a | b;
            4'd6:  r = ~a;
            4'd7:  r = a & b;
            4'd8:  r = a ^ b;
            4'd9:  r = a << 1;
            4'd10: r = a >> 1;
            default: return {1'b1, 16'hFFFF};
        endcase
        return {1'b0, 8'h00, r};
    endfunction

    logic [16:0] exp_q[$];
    logic [16:0] exp_e;

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_queue_empty", exp_q.size(), 1);
            end else begin
                exp_e = exp_q.pop_front();
                check("result", {15'h0, res_err, res_hi, res_lo}, {15'h0, exp_e});
            end
        end
    end

    logic [7:0]  t_log[0:19];
    logic [7:0]  b_log[0:19];
    logic        en_log[0:19];
    logic [10:0] sel_log[0:19];
    int          lat;

    // Called and returns at posedge+1.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, b, c, input int hold);
        int k, w;
        logic [16:0] e;
        e = model(op, a, b, c);
        exp_q.push_back(e);
        res_ready = (hold == 0);
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b; req_c = c;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("accept_wait", (w < 50), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!res_valid && k < 20) begin
            t_log[k] = alu_t; b_log[k] = alu_b; en_log[k] = alu_en; sel_log[k] = alu_sel;
            @(posedge clk); #1; k++;
        end
        lat = k;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_valid", res_valid, 1);
                check("hold_lo", res_lo, e[7:0]);
                check("hold_req_ready", req_ready, 0);
                @(posedge clk); #1;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            check("post_hs_valid", res_valid, 0);
            check("post_hs_req_ready", req_ready, 1);
        end else begin
            w = 0;
            while (res_valid && w < 20) begin
                @(posedge clk); #1; w++;
            end
            check("resp_drop", (w < 20), 1);
        end
        res_ready = 1'b1;
    endtask

    logic [3:0] simple_ops[7];
    logic [7:0] ra, rb, rc;
    int seen;

    initial begin
        simple_ops = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_ctl", {alu_sel, alu_en, alu_t}, 0);
        check("rst_res", {res_valid, res_err, res_lo, res_hi}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", req_ready, 1);

        // ADD
        run_op(4'd1, 8'h7F, 8'h01, 8'h00, 0);
        check("add_lat", lat, 2);
        check("add_t0", t_log[0], 8'h01);
        check("add_t1", t_log[1], 8'h02);
        check("add_en_t0", en_log[0], 0);
        check("add_en_t1", en_log[1], 1);
        check("add_sel", sel_log[0], 11'h002);

        // MUL
        run_op(4'd3, 8'h10, 8'h20, 8'h00, 0);
        check("mul_lat", lat, 8);
        for (int k = 0; k < 8; k++) begin
            check("mul_sel", sel_log[k], 11'h008);
            check("mul_t", t_log[k], 8'h01 << k);
            check("mul_en", en_log[k], (k >= 6));
        end

        // DIV
        run_op(4'd4, 8'h00, 8'h01, 8'h07, 0);
        check("div_lat", lat, 8);
        check("div_b_t3", b_log[3], 8'h01);
        check("div_b_t4", b_log[4], 8'h01);
        check("div_b_t5", b_log[5], 8'h07);
        check("div_sel", sel_log[0], 11'h010);

        // Error requests
        run_op(4'd4, 8'h12, 8'h00, 8'h00, 0);
        check("err_c0_lat", lat, 1);
        check("err_c0_sel", {sel_log[0], t_log[0]}, 0);
        run_op(4'd4, 8'h12, 8'h08, 8'h08, 0);
        check("err_ovf_lat", lat, 1);
        check("err_ovf_sel", {sel_log[0], t_log[0]}, 0);
        run_op(4'hC, 8'h12, 8'h34, 8'h56, 0);
        check("err_op_lat", lat, 1);
        check("err_op_sel", {sel_log[0], t_log[0], 7'h0, en_log[0]}, 0);

        // SUB with backpressure
        run_op(4'd2, 8'h05, 8'h07, 8'h00, 5);
        check("sub_lat", lat, 2);

        // Remaining single-beat ops and random MUL/DIV
        for (int i = 0; i < 7; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            run_op(simple_ops[i], ra, rb, 8'h00, 0);
            check("simple_lat", lat, 2);
            check("simple_sel", sel_log[0], 11'(1) << simple_ops[i]);
        end
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            run_op(4'd3, ra, rb, 8'h00, 0);
            rc = 8'($urandom_range(2, 255));
            rb = 8'($urandom_range(0, rc - 1));
            run_op(4'd4, ra, rb, rc, 0);
            check("rnd_div_lat", lat, 8);
        end

        // Reset during MUL beat T4
        req_valid = 1'b1; req_op = 4'd3; req_a = 8'h33; req_b = 8'h44;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_t4", alu_t, 8'h10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu", {alu_a, alu_b, alu_t}, 0);
        check("mid_rst_ctl", {alu_sel, alu_en, req_ready, res_valid, res_err}, 0);
        check("mid_rst_res", {res_lo, res_hi}, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | int'(res_valid);
        end
        check("mid_no_resp", seen, 0);
        run_op(4'd1, 8'h01, 8'h02, 8'h00, 0);
        check("post_rst_add_lat", lat, 2);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
